insn_encoder: RTL and testbench
===============================

INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the byte-address width of the word address counter (minimum 3).
REQ-002 SHALL have ports: clk  in  1  clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  request holds a valid instruction.
REQ-005 SHALL have port in_ready  out  1  encoder accepts the request this cycle.
REQ-006 SHALL have port op_sel  in  3  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 illegal.
REQ-007 SHALL have ports rd, rn, rm  in  5 each  register fields (rd = Rt for LDUR/STUR/CBZ).
REQ-008 SHALL have port imm  in  19  signed two's-complement offset (DT_address or COND_BR_address).
REQ-009 SHALL have port out_valid  out  1  out_word/out_addr hold an encoded word.
REQ-010 SHALL have port out_ready  in  1  consumer takes the word this cycle.
REQ-011 SHALL have port out_word  out  32  encoded LEGv8 instruction word.
REQ-012 SHALL have port out_addr  out  ADDR_W  byte address assigned to out_word.
REQ-013 SHALL have port err  out  1  one-cycle pulse for a rejected request.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid and in_ready are both 1.
REQ-015 SHALL encode R-type as {opcode[10:0], rm, 6'b0, rn, rd} with opcodes ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-016 SHALL encode D-type as {opcode[10:0], imm[8:0], 2'b00, rn, rd} with LDUR 11111000010, STUR 11111000000.
REQ-017 SHALL encode CBZ as {10110100, imm[18:0], rd}.
REQ-018 SHALL reject (not enqueue, no address consumed) op_sel 7, and LDUR/STUR with imm outside -256..255, asserting err for exactly the cycle after acceptance.
REQ-019 SHALL buffer encoded words in a 2-entry FIFO; state is count 0, 1, 2; in_ready = (count != 2), registered, with no combinational path from out_ready.
REQ-020 SHALL give a 1-cycle latency: a word accepted at edge N with an empty FIFO appears with out_valid=1 after edge N.
REQ-021 SHALL hold out_word, out_addr and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL support simultaneous enqueue and dequeue at count 1 (count stays 1, order preserved).
REQ-023 SHALL tag each enqueued word with the address counter value, then add 4 modulo 2^ADDR_W (wrap 2^ADDR_W-4 -> 0).
REQ-024 SHALL treat out_ready while out_valid=0 as no-op.

Reset
REQ-025 SHALL, on rst_n low, immediately clear FIFO (count 0), address counter to 0, out_valid=0, err=0, in_ready=0, out_word=0, out_addr=0.
REQ-026 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts; a request in flight at reset is discarded.

Configuration
REQ-027 SHALL, when INSN_ENC_ERR_CNT_EN is defined, add output err_cnt (8 bits, reset 0) incrementing on each err pulse and saturating at 255.
REQ-028 SHALL, when INSN_ENC_ERR_CNT_EN is undefined, omit err_cnt and its logic; all other behaviour identical.

Verification
REQ-029 SHALL cover ADD rd=1, rn=2, rm=3, out_ready=1 -> out_word 0x8B030041, out_addr 0x00, one cycle after acceptance.
REQ-030 SHALL cover LDUR rd=9, rn=22, imm=64 then CBZ rd=5, imm=-2 -> 0xF84402C9 @0x00, 0xB4FFFFC5 @0x04.
REQ-031 SHALL cover STUR imm=300, then op_sel=7 -> err pulses twice, no out_valid, next legal word gets address 0x00, err_cnt=2 with macro.
REQ-032 SHALL cover out_ready=0 with three back-to-back requests -> in_ready falls after two, third waits; releasing out_ready drains all three in order with addresses 0x00, 0x04, 0x08.
REQ-033 SHALL cover 64 consecutive ADDs at ADDR_W=8 -> 64th word at 0xFC, 65th at 0x00.
REQ-034 SHALL cover rst_n low with count 2 mid-transfer -> out_valid, err, in_ready 0 immediately; next word after release at address 0x00.

Source files
------------

// File: rtl/insn_encoder.sv
// LEGv8 instruction encoder with a 2-entry output FIFO and byte-address tagging.
// Optional saturating error counter output err_cnt when INSN_ENC_ERR_CNT_EN is defined.
module insn_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [18:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
`ifdef INSN_ENC_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} fill_e;

  fill_e             state_q, state_d;
  logic [31:0]       word0_q, word0_d, word1_q, word1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              in_ready_q, err_q, err_d;
  logic [31:0]       enc_word;
  logic              legal, imm_fits, acc, enq, deq;

  // D-type offsets are 9 bits: every bit above bit 8 must repeat the sign.
  assign imm_fits = (imm[18:8] == '0) || (imm[18:8] == '1);

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (op_sel)
      3'd0: enc_word = {11'b10001011000, rm, 6'b000000, rn, rd};
      3'd1: enc_word = {11'b11001011000, rm, 6'b000000, rn, rd};
      3'd2: enc_word = {11'b10001010000, rm, 6'b000000, rn, rd};
      3'd3: enc_word = {11'b10101010000, rm, 6'b000000, rn, rd};
      3'd4: begin
        enc_word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        legal    = imm_fits;
      end
      3'd5: begin
        enc_word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        legal    = imm_fits;
      end
      3'd6: enc_word = {8'b10110100, imm, rd};
      default: legal = 1'b0;
    endcase
  end

  assign acc   = in_valid & in_ready_q;
  assign enq   = acc & legal;
  assign err_d = acc & ~legal;
  assign deq   = out_ready & (state_q != EMPTY);
  assign pc_d  = enq ? pc_q + ADDR_W'(4) : pc_q;

  // Slot 0 is always the head, so the output ports come straight from registers.
  always_comb begin
    state_d = state_q;
    word0_d = word0_q;
    word1_d = word1_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    case (state_q)
      EMPTY: if (enq) begin
        word0_d = enc_word;
        addr0_d = pc_q;
        state_d = ONE;
      end
      ONE: begin
        if (enq && deq) begin
          word0_d = enc_word;
          addr0_d = pc_q;
        end else if (enq) begin
          word1_d = enc_word;
          addr1_d = pc_q;
          state_d = FULL;
        end else if (deq) begin
          state_d = EMPTY;
        end
      end
      FULL: if (deq) begin
        word0_d = word1_q;
        addr0_d = addr1_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      word0_q    <= '0;
      word1_q    <= '0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      pc_q       <= '0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word0_q    <= word0_d;
      word1_q    <= word1_d;
      addr0_q    <= addr0_d;
      addr1_q    <= addr1_d;
      pc_q       <= pc_d;
      in_ready_q <= (state_d != FULL);
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_word  = word0_q;
  assign out_addr  = addr0_q;
  assign err       = err_q;

`ifdef INSN_ENC_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: directed vector table, multi-cycle
// sequences and random traffic compared against a queue-based reference model.
module tb_insn_encoder;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op_sel = '0;
  logic [4:0]    rd = '0, rn = '0, rm = '0;
  logic [18:0]   imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          err;
`ifdef INSN_ENC_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  insn_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .err(err)
`ifdef INSN_ENC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0]   w;
    logic [AW-1:0] a;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  logic          m_ready, m_err;
  int            m_cnt;

  function automatic logic [31:0] ref_enc(input int unsigned op, input int unsigned d,
                                          input int unsigned n, input int unsigned m,
                                          input int immv);
    int unsigned base;
    int unsigned t;
    case (op)
      0: base = 32'h458;
      1: base = 32'h658;
      2: base = 32'h450;
      3: base = 32'h550;
      4: base = 32'h7C2;
      5: base = 32'h7C0;
      default: base = 0;
    endcase
    if (op == 6) begin
      t = immv & 32'h7FFFF;
      return 32'hB400_0000 + t * 32 + d;
    end
    if (op >= 4) begin
      t = immv & 32'h1FF;
      return base * (2 ** 21) + t * 4096 + n * 32 + d;
    end
    return base * (2 ** 21) + m * 65536 + n * 32 + d;
  endfunction

  function automatic bit ref_legal(input int unsigned op, input int immv);
    if (op == 7) return 1'b0;
    if ((op == 4 || op == 5) && (immv < -256 || immv > 255)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = '0;
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    int immv;
    ent_t e;
    immv = $signed(imm);
    if (out_ready && mq.size() != 0) void'(mq.pop_front());
    m_err = 1'b0;
    if (in_valid && m_ready) begin
      if (ref_legal(op_sel, immv)) begin
        e.w = ref_enc(op_sel, rd, rn, rm, immv);
        e.a = m_pc;
        mq.push_back(e);
        m_pc = m_pc + AW'(4);
      end else begin
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_ready = (mq.size() != 2);
  endtask

  task automatic model_check();
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("err", 32'(err), 32'(m_err));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_word", out_word, mq[0].w);
      chk("out_addr", 32'(out_addr), 32'(mq[0].a));
    end
`ifdef INSN_ENC_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_word"}, out_word, 0);
    chk({tag, "_out_addr"}, 32'(out_addr), 0);
`ifdef INSN_ENC_ERR_CNT_EN
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_req(input logic [2:0] o, input logic [4:0] d, input logic [4:0] n,
                         input logic [4:0] m, input logic [18:0] i);
    op_sel = o; rd = d; rn = n; rm = m; imm = i;
  endtask

  typedef struct {
    bit          rst;
    logic [2:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [18:0] imm;
    logic [31:0] word;
    bit          e;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0]   capw[3];
    logic [AW-1:0] capa[3];
    logic [31:0]   ew[3];
    int            ncap;
    bit            took;
    logic [AW-1:0] exp_addr;
    int            tmp;

    tbl[0]  = '{1, 3'd0, 5'd1,  5'd2,  5'd3,  19'd0,       32'h8B030041, 0};
    tbl[1]  = '{1, 3'd4, 5'd9,  5'd22, 5'd0,  19'd64,      32'hF84402C9, 0};
    tbl[2]  = '{0, 3'd6, 5'd5,  5'd0,  5'd0,  19'h7FFFE,   32'hB4FFFFC5, 0};
    tbl[3]  = '{1, 3'd5, 5'd1,  5'd2,  5'd0,  19'd300,     32'h0,        1};
    tbl[4]  = '{0, 3'd7, 5'd1,  5'd2,  5'd3,  19'd0,       32'h0,        1};
    tbl[5]  = '{0, 3'd1, 5'd0,  5'd0,  5'd0,  19'd0,       32'hCB000000, 0};
    tbl[6]  = '{0, 3'd2, 5'd0,  5'd0,  5'd0,  19'd0,       32'h8A000000, 0};
    tbl[7]  = '{0, 3'd3, 5'd31, 5'd31, 5'd31, 19'd0,       32'hAA1F03FF, 0};
    tbl[8]  = '{0, 3'd5, 5'd1,  5'd2,  5'd0,  19'h7FF00,   32'hF8100041, 0};
    tbl[9]  = '{0, 3'd4, 5'd0,  5'd0,  5'd0,  19'd255,     32'hF84FF000, 0};
    tbl[10] = '{0, 3'd4, 5'd0,  5'd0,  5'd0,  19'd256,     32'h0,        1};
    tbl[11] = '{0, 3'd4, 5'd0,  5'd0,  5'd0,  19'h7FEFF,   32'h0,        1};

    model_reset();
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table vectors, each accepted from an empty or single-entry FIFO
    exp_addr = '0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) begin
        do_reset();
        exp_addr = '0;
        out_ready = 1'b1;
        tick();
      end
      set_req(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (tbl[i].e) begin
        chk($sformatf("tbl%0d_err", i), 32'(err), 1);
        chk($sformatf("tbl%0d_no_valid", i), 32'(out_valid), 0);
      end else begin
        chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
        chk($sformatf("tbl%0d_word", i), out_word, tbl[i].word);
        chk($sformatf("tbl%0d_addr", i), 32'(out_addr), 32'(exp_addr));
        exp_addr = exp_addr + AW'(4);
      end
`ifdef INSN_ENC_ERR_CNT_EN
      if (i == 5) chk("err_cnt_two", 32'(err_cnt), 2);
`endif
    end
    tick();
    chk("err_one_cycle", 32'(err), 0);

    // Backpressure: two fill the FIFO, the third waits, then all drain in order
    do_reset();
    out_ready = 1'b0;
    tick();
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 19'd0);
    ew[0] = ref_enc(0, 1, 2, 3, 0);
    in_valid = 1'b1;
    tick();
    set_req(3'd1, 5'd4, 5'd5, 5'd6, 19'd0);
    ew[1] = ref_enc(1, 4, 5, 6, 0);
    tick();
    chk("full_in_ready", 32'(in_ready), 0);
    set_req(3'd3, 5'd7, 5'd8, 5'd9, 19'd0);
    ew[2] = ref_enc(3, 7, 8, 9, 0);
    tick();
    chk("full_hold_in_ready", 32'(in_ready), 0);
    chk("full_hold_head", out_word, ew[0]);
    out_ready = 1'b1;
    ncap = 0;
    for (int c = 0; c < 10 && ncap < 3; c++) begin
      if (out_valid) begin
        capw[ncap] = out_word;
        capa[ncap] = out_addr;
        ncap++;
      end
      took = in_valid && in_ready;
      tick();
      if (took) in_valid = 1'b0;
    end
    chk("drain_count", 32'(ncap), 3);
    for (int k = 0; k < ncap; k++) begin
      chk($sformatf("drain%0d_word", k), capw[k], ew[k]);
      chk($sformatf("drain%0d_addr", k), 32'(capa[k]), 32'(k * 4));
    end
    in_valid = 1'b0;

    // Address wrap over 65 back-to-back words
    do_reset();
    out_ready = 1'b1;
    tick();
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 19'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 65; i++) begin
      tick();
      if (i == 63) chk("wrap_64th_addr", 32'(out_addr), 32'hFC);
      if (i == 64) chk("wrap_65th_addr", 32'(out_addr), 32'h00);
    end
    in_valid = 1'b0;
    tick();

    // Reset while full with a request pending
    do_reset();
    out_ready = 1'b0;
    tick();
    set_req(3'd2, 5'd3, 5'd4, 5'd5, 19'd0);
    in_valid = 1'b1;
    tick();
    tick();
    chk("pre_rst_full", 32'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    tick();
    chk("post_rst_discard", 32'(out_valid), 0);
    tick();
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_addr", 32'(out_addr), 0);
    in_valid = 1'b0;
    tick();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op_sel    = 3'($urandom_range(0, 7));
      rd        = 5'($urandom);
      rn        = 5'($urandom);
      rm        = 5'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        imm = 19'($urandom);
      end else begin
        tmp = int'($urandom_range(0, 600)) - 300;
        imm = 19'(tmp);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
